// File: rtl/fog_err_demod.sv
`default_nettype none
// ============================================================================
//  Module   : fog_err_demod
//  Purpose  : Square-wave bias modulator and synchronous error demodulator
//             for a fibre-optic gyro loop. Alternates HIGH/LOW half-periods
//             of Neff = max(N,4) clocks, integrates ADC samples after Weff =
//             min(W,Neff-1) settle clocks in each half, and at every LOW->HIGH
//             boundary emits err = acc_H - acc_L and step = err >>> gain.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk          clock, rising edge
//    i_rst_n        asynchronous active-low reset
//    i_en           run enable; low forces IDLE on the next clock
//    i_adc          signed photodetector sample (ADC_BIT)
//    i_adc_vld      i_adc qualifier
//    i_half_period  N, clocks per half-period (sampled on HIGH entry)
//    i_wait_cnt     W, settle clocks per half (sampled on HIGH entry)
//    i_amp_H/L      modulation levels for HIGH / LOW
//    i_err_gain     arithmetic right shift applied to the error
//    o_mod          registered modulation word
//    o_mod_trig     pulse on the first clock of every half
//    o_err, o_step  raw and scaled error, held between updates
//    o_step_vld     pulse when o_err/o_step update
//    o_state        0 IDLE, 1 HIGH, 2 LOW
//  Build option
//    FOG_DEMOD_STEP_SAT_EN  clamp o_step to [-8388608, +8388607]
// ============================================================================
module fog_err_demod #(
  parameter int ADC_BIT    = 14,
  parameter int OUTPUT_BIT = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic signed [ADC_BIT-1:0]    i_adc,
  input  logic                         i_adc_vld,
  input  logic        [31:0]           i_half_period,
  input  logic        [31:0]           i_wait_cnt,
  input  logic signed [31:0]           i_amp_H,
  input  logic signed [31:0]           i_amp_L,
  input  logic        [4:0]            i_err_gain,
  output logic signed [OUTPUT_BIT-1:0] o_mod,
  output logic                         o_mod_trig,
  output logic signed [OUTPUT_BIT-1:0] o_err,
  output logic signed [OUTPUT_BIT-1:0] o_step,
  output logic                         o_step_vld,
  output logic        [1:0]            o_state
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_HIGH = 2'd1;
  localparam logic [1:0] c_LOW  = 2'd2;

  logic        [1:0]            r_state;
  logic        [31:0]           r_cnt;
  logic        [31:0]           r_neff;
  logic        [31:0]           r_weff;
  logic signed [31:0]           r_acc_h;
  logic signed [31:0]           r_acc_l;

  logic        [31:0]           w_neff_in;
  logic        [31:0]           w_weff_in;
  logic                         w_last;
  logic                         w_take;
  logic                         w_enter_high;
  logic signed [31:0]           w_adc_ext;
  logic signed [31:0]           w_acc_l_fin;
  logic signed [31:0]           w_err32;
  logic signed [OUTPUT_BIT-1:0] w_err;
  logic signed [OUTPUT_BIT-1:0] w_shift;
  logic signed [OUTPUT_BIT-1:0] w_step;

  assign w_neff_in    = (i_half_period < 32'd4) ? 32'd4 : i_half_period;
  assign w_weff_in    = (i_wait_cnt > (w_neff_in - 32'd1)) ? (w_neff_in - 32'd1) : i_wait_cnt;
  assign w_last       = (r_cnt == (r_neff - 32'd1));
  assign w_take       = i_adc_vld && (r_cnt >= r_weff);
  assign w_adc_ext    = 32'(i_adc);
  assign w_enter_high = i_en && ((r_state == c_IDLE) || ((r_state == c_LOW) && w_last));

  // The final LOW sample lands in the same clock as the error update, so it is
  // folded in combinationally rather than waiting for the accumulator.
  assign w_acc_l_fin  = w_take ? (r_acc_l + w_adc_ext) : r_acc_l;
  assign w_err32      = r_acc_h - w_acc_l_fin;
  assign w_err        = OUTPUT_BIT'(w_err32);
  assign w_shift      = w_err >>> i_err_gain;

`ifdef FOG_DEMOD_STEP_SAT_EN
  localparam logic signed [OUTPUT_BIT-1:0] c_SAT_MAX = OUTPUT_BIT'(8388607);
  localparam logic signed [OUTPUT_BIT-1:0] c_SAT_MIN = OUTPUT_BIT'(-8388608);

  always_comb begin
    w_step = w_shift;
    if (w_shift > c_SAT_MAX) begin
      w_step = c_SAT_MAX;
    end else if (w_shift < c_SAT_MIN) begin
      w_step = c_SAT_MIN;
    end
  end
`else
  assign w_step = w_shift;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= 32'd0;
      r_neff     <= 32'd4;
      r_weff     <= 32'd3;
      r_acc_h    <= 32'sd0;
      r_acc_l    <= 32'sd0;
      o_mod      <= '0;
      o_mod_trig <= 1'b0;
      o_err      <= '0;
      o_step     <= '0;
      o_step_vld <= 1'b0;
    end else begin
      o_mod_trig <= 1'b0;
      o_step_vld <= 1'b0;
      if (!i_en) begin
        // Abort: partial sums dropped, last error/step kept.
        r_state <= c_IDLE;
        r_cnt   <= 32'd0;
        r_acc_h <= 32'sd0;
        r_acc_l <= 32'sd0;
        o_mod   <= '0;
      end else if (w_enter_high) begin
        r_state    <= c_HIGH;
        r_cnt      <= 32'd0;
        r_neff     <= w_neff_in;
        r_weff     <= w_weff_in;
        r_acc_h    <= 32'sd0;
        r_acc_l    <= 32'sd0;
        o_mod      <= OUTPUT_BIT'(i_amp_H);
        o_mod_trig <= 1'b1;
        // Only a completed LOW half produces a new error; IDLE entry does not.
        if (r_state == c_LOW) begin
          o_err      <= w_err;
          o_step     <= w_step;
          o_step_vld <= 1'b1;
        end
      end else if (r_state == c_HIGH) begin
        if (w_take) begin
          r_acc_h <= r_acc_h + w_adc_ext;
        end
        if (w_last) begin
          r_state    <= c_LOW;
          r_cnt      <= 32'd0;
          o_mod      <= OUTPUT_BIT'(i_amp_L);
          o_mod_trig <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end else if (r_state == c_LOW) begin
        r_acc_l <= w_acc_l_fin;
        r_cnt   <= r_cnt + 32'd1;
      end else begin
        r_state <= c_IDLE;
        r_cnt   <= 32'd0;
        o_mod   <= '0;
      end
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: doc/fog_err_demod.md
FOG_ERR_DEMOD -- requirements
Module: fog_err_demod

Interface
REQ-001 SHALL have parameter ADC_BIT, default 14: signed ADC sample width.
REQ-002 SHALL have parameter OUTPUT_BIT, default 32: signed width of o_mod, o_err and o_step.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_en, input, 1 bit: enables modulation and demodulation.
REQ-006 SHALL have port i_adc, input, ADC_BIT bits, signed: photodetector sample.
REQ-007 SHALL have port i_adc_vld, input, 1 bit: i_adc is valid this cycle.
REQ-008 SHALL have port i_half_period, input, 32 bits: N, the number of clocks per modulation half-period.
REQ-009 SHALL have port i_wait_cnt, input, 32 bits: W, the number of settle clocks discarded at the start of each half.
REQ-010 SHALL have ports i_amp_H and i_amp_L, input, 32 bits each, signed: modulation levels.
REQ-011 SHALL have port i_err_gain, input, 5 bits: arithmetic right-shift applied to the error.
REQ-012 SHALL have port o_mod, output, OUTPUT_BIT bits, signed, registered: modulation word; drives i_mod of the ramp generator.
REQ-013 SHALL have port o_mod_trig, output, 1 bit: one-cycle pulse on the first clock of each half-period.
REQ-014 SHALL have port o_err, output, OUTPUT_BIT bits, signed: raw error, acc_H - acc_L.
REQ-015 SHALL have port o_step, output, OUTPUT_BIT bits, signed: scaled error; drives i_step of the ramp generator.
REQ-016 SHALL have port o_step_vld, output, 1 bit: one-cycle pulse when o_err and o_step update.
REQ-017 SHALL have port o_state, output, 2 bits: 0 = IDLE, 1 = HIGH, 2 = LOW.

Function
REQ-018 SHALL implement an FSM with states IDLE, HIGH and LOW; IDLE goes to HIGH on the first clock with i_en=1.
REQ-019 SHALL hold each of HIGH and LOW for exactly Neff clocks, then go HIGH->LOW or LOW->HIGH.
REQ-020 SHALL sample N and W at every entry to HIGH and hold them for the full period.
REQ-021 SHALL compute Neff = max(N, 4) and Weff = min(W, Neff-1).
REQ-022 SHALL use a half-period counter that is 0 on the first clock of each half and ends at Neff-1.
REQ-023 SHALL drive o_mod = i_amp_H while in HIGH, i_amp_L while in LOW, and 0 in IDLE; o_mod is registered and o_mod_trig is aligned with its change.
REQ-024 SHALL, when i_adc_vld=1 and counter >= Weff, add sign-extended i_adc to acc_H (in HIGH) or acc_L (in LOW); the 32-bit signed accumulators wrap.
REQ-025 SHALL clear acc_H and acc_L on entry to HIGH.
REQ-026 SHALL, on the LOW->HIGH transition, register o_err = acc_H - acc_L (including the last LOW sample) and o_step = o_err >>> i_err_gain.
REQ-027 SHALL pulse o_step_vld on the first HIGH clock, coincident with o_mod_trig, so latency is 1 clock after the last LOW sample.
REQ-028 SHALL hold o_err and o_step between updates.
REQ-029 SHALL, when i_en falls in any state, go to IDLE on the next clock: o_mod=0, no o_mod_trig, no o_step_vld, partial sums discarded, o_err and o_step held.
REQ-030 SHALL, when i_en rises, start a full HIGH half at counter 0 with o_mod_trig=1.

Reset
REQ-031 SHALL, with i_rst_n=0 at any time including mid-period, put the FSM in IDLE, zero counter, accumulators, o_mod, o_err and o_step, and set o_mod_trig=0 and o_step_vld=0.
REQ-032 SHALL, after reset release, behave exactly as on an i_en rising edge.

Configuration
REQ-033 SHALL compile in step saturation when macro FOG_DEMOD_STEP_SAT_EN is defined: o_step is clamped to [-8388608, +8388607] after the shift; o_err is unaffected.
REQ-034 SHALL, when FOG_DEMOD_STEP_SAT_EN is undefined, deliver o_step as the unclamped shift result.

Verification
REQ-035 SHALL cover: N=8, W=2, gain=0, i_adc=100 constant, vld=1 -> o_err=0, o_step=0, o_step_vld period 16 clocks, o_mod_trig every 8.
REQ-036 SHALL cover: N=8, W=2, gain=2, i_adc=+100 in HIGH and -100 in LOW -> o_err=1200, o_step=300.
REQ-037 SHALL cover: N=2, W=9 -> halves are 4 clocks, only the last sample of each half is accumulated.
REQ-038 SHALL cover: N=1000, W=0, gain=0, i_adc=8191 in HIGH and -8192 in LOW -> o_err=16383000; o_step=8388607 with macro, 16383000 without.
REQ-039 SHALL cover: i_en dropped mid-LOW then raised -> o_mod=0 in between, no step pulse, first new o_step_vld after 2N clocks.
REQ-040 SHALL cover: i_rst_n asserted mid-HIGH -> all outputs 0 asynchronously, and on release a HIGH half starts with o_mod_trig=1.
